// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract datapath.
//   op_e           : operation select carried on in_op (OP_ADD=0, OP_SUB=1)
//   carry_in_for() : carry fed into the LSB chunk for a given operation
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Subtraction is a + ~b + 1; the borrow-in is folded in by inverting cin,
  // so SUB with cin=1 yields a - b - 1.
  function automatic logic carry_in_for(op_e op, logic cin);
    logic c;
    if (op == OP_SUB) begin
      c = ~cin;
    end else begin
      c = cin;
    end
    return c;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// Combinational CHUNK-bit ripple of full-adder cells, one per pipeline stage.
//   a, b  : in  CHUNK  operand chunk (b already inverted for subtraction)
//   cin   : in  1      carry into the chunk LSB
//   sum   : out CHUNK  chunk sum
//   cout  : out 1      carry out of the chunk MSB
//   cmsb  : out 1      carry into the chunk MSB (cmsb ^ cout is signed overflow)
module adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] carry_s;

  // Ripple the carry through CHUNK full-adder cells, LSB first.
  always_comb begin
    carry_s    = {(CHUNK+1){1'b0}};
    sum        = {CHUNK{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[CHUNK];
    cmsb = carry_s[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready on both sides.
// The operation is split into STAGES chunks of CHUNK bits; stage k adds
// bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_op, in_a, in_b     : operation and operands
//   in_cin                : carry-in (ADD) / borrow-in (SUB)
//   out_valid / out_ready : output handshake
//   out_sum, out_cout     : result and carry-out (NOT borrow-out for SUB)
//   out_ovf               : signed two's-complement overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
  end

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  // Stage registers. Operands travel full width; each stage only consumes
  // its own chunk, the lower result bits accumulate in sum_r.
  logic             valid_r [STAGES];
  logic             carry_r [STAGES];
  logic [WIDTH-1:0] sum_r   [STAGES];
  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] b_r     [STAGES];
  logic             ovf_r;

  logic [CHUNK-1:0] st_a_s    [STAGES];
  logic [CHUNK-1:0] st_b_s    [STAGES];
  logic             st_cin_s  [STAGES];
  logic [CHUNK-1:0] st_sum_s  [STAGES];
  logic             st_cout_s [STAGES];
  logic             st_cmsb_s [STAGES];
  logic [WIDTH-1:0] sum_next_s[STAGES];

  // One global stall: the whole pipe moves only when the output slot frees.
  assign advance_s = !valid_r[STAGES-1] || out_ready;
  assign in_ready  = advance_s;

  assign out_valid = valid_r[STAGES-1];
  assign out_sum   = sum_r[STAGES-1];
  assign out_cout  = carry_r[STAGES-1];
  assign out_ovf   = ovf_r;

  // Fold the operation into an effective B operand and LSB carry.
  always_comb begin
    if (in_op == OP_SUB) begin
      b_eff_s = ~in_b;
    end else begin
      b_eff_s = in_b;
    end
    c0_s = carry_in_for(in_op, in_cin);
  end

  // Select each stage's operand chunk and incoming carry.
  always_comb begin
    st_a_s[0]   = in_a[CHUNK-1:0];
    st_b_s[0]   = b_eff_s[CHUNK-1:0];
    st_cin_s[0] = c0_s;
    for (int k = 1; k < STAGES; k++) begin
      st_a_s[k]   = a_r[k-1][k*CHUNK +: CHUNK];
      st_b_s[k]   = b_r[k-1][k*CHUNK +: CHUNK];
      st_cin_s[k] = carry_r[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .a    (st_a_s[k]),
      .b    (st_b_s[k]),
      .cin  (st_cin_s[k]),
      .sum  (st_sum_s[k]),
      .cout (st_cout_s[k]),
      .cmsb (st_cmsb_s[k])
    );
  end

  // Merge each stage's new chunk into the partial sum handed down the pipe.
  always_comb begin
    sum_next_s[0]            = {WIDTH{1'b0}};
    sum_next_s[0][CHUNK-1:0] = st_sum_s[0];
    for (int k = 1; k < STAGES; k++) begin
      sum_next_s[k]                  = sum_r[k-1];
      sum_next_s[k][k*CHUNK +: CHUNK] = st_sum_s[k];
    end
  end

  // Stage registers: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        sum_r[k]   <= {WIDTH{1'b0}};
        a_r[k]     <= {WIDTH{1'b0}};
        b_r[k]     <= {WIDTH{1'b0}};
      end
      ovf_r <= 1'b0;
    end else if (advance_s) begin
      valid_r[0] <= in_valid && advance_s;
      a_r[0]     <= in_a;
      b_r[0]     <= b_eff_s;
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
        a_r[k]     <= a_r[k-1];
        b_r[k]     <= b_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        carry_r[k] <= st_cout_s[k];
        sum_r[k]   <= sum_next_s[k];
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf_r <= st_cmsb_s[STAGES-1] ^ st_cout_s[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: three instances (STAGES 1, 4, 16)
// share stimulus; a per-instance scoreboard queue holds expected results.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_cin, out_ready;
  op_e          in_op;
  logic [W-1:0] in_a, in_b;

  logic [2:0]        rdy, ov, oc, of;
  logic [2:0][W-1:0] osum;

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[0]), .out_ready(out_ready),
    .out_sum(osum[0]), .out_cout(oc[0]), .out_ovf(of[0]));

  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[1]), .out_ready(out_ready),
    .out_sum(osum[1]), .out_cout(oc[1]), .out_ovf(of[1]));

  pipelined_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[2]), .out_ready(out_ready),
    .out_sum(osum[2]), .out_cout(oc[2]), .out_ovf(of[2]));

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];

  // Reference: {ovf, cout, sum} from plain add / subtract arithmetic.
  function automatic logic [17:0] model(op_e op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
    logic [16:0] r;
    logic        v;
    if (op == OP_ADD) begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      v = (a[15] == b[15]) && (r[15] != a[15]);
      return {v, r[16], r[15:0]};
    end else begin
      r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      v = (a[15] != b[15]) && (r[15] != a[15]);
      return {v, ~r[16], r[15:0]};
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called once per cycle at the falling edge: pop/compare outputs that
  // handshake at the next rising edge, then push inputs that will be accepted.
  task automatic sb_sample();
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (ov[0] && out_ready) begin
        if (q0.size() == 0) check("sb_s1_extra", q0.size(), 32'd1);
        else check("sb_s1_result", {of[0], oc[0], osum[0]}, q0.pop_front());
      end
      if (ov[1] && out_ready) begin
        if (q1.size() == 0) check("sb_s4_extra", q1.size(), 32'd1);
        else check("sb_s4_result", {of[1], oc[1], osum[1]}, q1.pop_front());
      end
      if (ov[2] && out_ready) begin
        if (q2.size() == 0) check("sb_s16_extra", q2.size(), 32'd1);
        else check("sb_s16_result", {of[2], oc[2], osum[2]}, q2.pop_front());
      end
      if (in_valid && rdy[0]) q0.push_back(model(in_op, in_a, in_b, in_cin));
      if (in_valid && rdy[1]) q1.push_back(model(in_op, in_a, in_b, in_cin));
      if (in_valid && rdy[2]) q2.push_back(model(in_op, in_a, in_b, in_cin));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  // One transaction on an idle STAGES=4 pipe: latency, result, one-cycle valid.
  task automatic run_vec(vec_t v, string tag);
    int lat;
    lat      = 0;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, rdy[1], 32'd1);
    cycle();
    in_valid = 1'b0;
    while (!ov[1] && lat < 10) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_result"}, {of[1], oc[1], osum[1]}, {v.ovf, v.cout, v.sum});
    cycle();
    check({tag, "_valid_one_cycle"}, ov[1], 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    vec_t         v;
    int           sent;
    logic [W-1:0] held;
    logic [W-1:0] outs[$];

    vecs[0] = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{OP_ADD, 16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0, 1'b0};
    vecs[3] = '{OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{OP_SUB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{OP_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = OP_ADD;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_cin    = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    // Reset state.
    check("rst_out_valid", ov, 32'd0);
    check("rst_out_sum", osum[1], 32'd0);
    check("rst_out_cout", oc, 32'd0);
    check("rst_out_ovf", of, 32'd0);
    rst = 1'b0;
    cycle();
    check("ready_after_rst", rdy, 32'd7);
    out_ready = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    repeat (20) cycle();

    // Backpressure: 8 back-to-back inputs, out_ready low in cycles 5..7.
    sent = 0;
    held = 16'h0000;
    for (int cyc = 0; cyc < 25; cyc++) begin
      in_valid  = (sent < 8);
      in_op     = OP_ADD;
      in_a      = sent[15:0];
      in_b      = sent[15:0];
      in_cin    = 1'b0;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      check($sformatf("bp_in_ready_c%0d", cyc), rdy[1], (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
      if (cyc == 5) held = osum[1];
      if (cyc == 6 || cyc == 7) begin
        check($sformatf("bp_hold_valid_c%0d", cyc), ov[1], 32'd1);
        check($sformatf("bp_hold_sum_c%0d", cyc), osum[1], held);
      end
      if (ov[1] && out_ready) outs.push_back(osum[1]);
      if (in_valid && rdy[1]) sent++;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", outs.size(), 32'd8);
    for (int i = 0; i < outs.size(); i++) begin
      check($sformatf("bp_order_%0d", i), outs[i], 2 * i);
    end
    repeat (20) cycle();

    // Reset mid-flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = 16'd100 + i[15:0];
      in_b     = 16'h0001;
      cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_in_ready", rdy, 32'd7);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("mid_rst_valid_%0d", j), ov, 32'd0);
      cycle();
    end
    v = '{OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    run_vec(v, "post_rst");
    repeat (20) cycle();

    // Random traffic on all three depths.
    for (int cyc = 0; cyc < 14000; cyc++) begin
      in_valid  = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 7) != 0);
      in_op     = op_e'($urandom_range(0, 1));
      in_a      = 16'($urandom_range(0, 65535));
      in_b      = 16'($urandom_range(0, 65535));
      in_cin    = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) cycle();
    check("drain_s1", q0.size(), 32'd0);
    check("drain_s4", q1.size(), 32'd0);
    check("drain_s16", q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
